// File: rtl/overlay_fade_mixer.sv
// rtl/overlay_fade_mixer.sv - frame-timed overlay fade/hold/blink mixer with registered RGB222 and sync outputs
module overlay_fade_mixer #(
    parameter logic [5:0] OVL_COLOR    = 6'b111111,
    parameter int         HIDE_FRAMES  = 60,
    parameter int         FADE_FRAMES  = 8,
    parameter int         HOLD_FRAMES  = 120,
    parameter int         BLINK_FRAMES = 15,
    parameter int         BLINK_COUNT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic       overlay_active,
    input  logic [5:0] bg_rgb,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic [1:0] level,
    output logic [2:0] phase
);

    localparam logic [2:0] ST_HIDDEN   = 3'd0;
    localparam logic [2:0] ST_FADE_IN  = 3'd1;
    localparam logic [2:0] ST_SHOW     = 3'd2;
    localparam logic [2:0] ST_BLINK    = 3'd3;
    localparam logic [2:0] ST_FADE_OUT = 3'd4;

    // Terminal counts: a phase step happens on the tick where the counter
    // already holds N-1, so each step lasts exactly N ticks.
    localparam logic [7:0] HIDE_LAST  = 8'(HIDE_FRAMES - 1);
    localparam logic [7:0] FADE_LAST  = 8'(FADE_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] BLINK_N    = 8'(BLINK_COUNT);

    logic [2:0] state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_vis_q, blink_vis_d;
    logic       vs_hist_q, vs_hist_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [5:0] rgb_q, rgb_d;

    logic       frame_tick;
    logic [7:0] frame_cnt_inc;
    logic [7:0] blink_cnt_inc;

    function automatic logic [1:0] chan_min(input logic [1:0] c, input logic [1:0] l);
        return (c < l) ? c : l;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Frame tick on the falling edge of vsync_in, seen against last cycle's value.
    always_comb begin
        frame_tick    = vs_hist_q & ~vsync_in;
        frame_cnt_inc = sat_inc(frame_cnt_q);
        blink_cnt_inc = sat_inc(blink_cnt_q);
    end

    // State and animation register bank, plus the 1-clk output pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HIDDEN;
            level_q     <= 2'd0;
            frame_cnt_q <= 8'd0;
            blink_cnt_q <= 8'd0;
            blink_vis_q <= 1'b1;
            vs_hist_q   <= 1'b1;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= 6'd0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
            vs_hist_q   <= vs_hist_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
        end
    end

    // Next-state and counter logic; everything holds except on a frame tick,
    // apart from illegal state codes which recover immediately.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;

        if (state_q > ST_FADE_OUT) begin
            state_d     = ST_HIDDEN;
            level_d     = 2'd0;
            frame_cnt_d = 8'd0;
            blink_cnt_d = 8'd0;
            blink_vis_d = 1'b1;
        end else if (frame_tick) begin
            if (!enable) begin
                state_d     = ST_HIDDEN;
                level_d     = 2'd0;
                frame_cnt_d = 8'd0;
                blink_cnt_d = 8'd0;
                blink_vis_d = 1'b1;
            end else begin
                case (state_q)
                    ST_HIDDEN: begin
                        level_d = 2'd0;
                        if (frame_cnt_q == HIDE_LAST) begin
                            state_d     = ST_FADE_IN;
                            frame_cnt_d = 8'd0;
                        end else begin
                            frame_cnt_d = frame_cnt_inc;
                        end
                    end
                    ST_FADE_IN: begin
                        if (frame_cnt_q == FADE_LAST) begin
                            frame_cnt_d = 8'd0;
                            if (level_q >= 2'd2) begin
                                level_d = 2'd3;
                                state_d = ST_SHOW;
                            end else begin
                                level_d = level_q + 2'd1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_inc;
                        end
                    end
                    ST_SHOW: begin
                        level_d = 2'd3;
                        if (frame_cnt_q == HOLD_LAST) begin
                            state_d     = ST_BLINK;
                            frame_cnt_d = 8'd0;
                            blink_cnt_d = 8'd0;
                            blink_vis_d = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_inc;
                        end
                    end
                    ST_BLINK: begin
                        level_d = 2'd3;
                        if (frame_cnt_q == BLINK_LAST) begin
                            frame_cnt_d = 8'd0;
                            blink_vis_d = ~blink_vis_q;
                            // A full off/on period completes when turning back on.
                            if (!blink_vis_q) begin
                                if (blink_cnt_inc >= BLINK_N) begin
                                    state_d     = ST_FADE_OUT;
                                    blink_cnt_d = 8'd0;
                                    blink_vis_d = 1'b1;
                                end else begin
                                    blink_cnt_d = blink_cnt_inc;
                                end
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_inc;
                        end
                    end
                    ST_FADE_OUT: begin
                        blink_vis_d = 1'b1;
                        if (frame_cnt_q == FADE_LAST) begin
                            frame_cnt_d = 8'd0;
                            if (level_q <= 2'd1) begin
                                level_d = 2'd0;
                                state_d = ST_HIDDEN;
                            end else begin
                                level_d = level_q - 2'd1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_inc;
                        end
                    end
                    default: begin
                        state_d = ST_HIDDEN;
                    end
                endcase
            end
        end
    end

    // Pixel and sync pipeline; uses the level held before any tick this cycle.
    always_comb begin
        vs_hist_d = vsync_in;
        hsync_d   = hsync_in;
        vsync_d   = vsync_in;
        if (!display_on) begin
            rgb_d = 6'd0;
        end else if (overlay_active && (level_q != 2'd0) && blink_vis_q) begin
            rgb_d = {chan_min(OVL_COLOR[5:4], level_q),
                     chan_min(OVL_COLOR[3:2], level_q),
                     chan_min(OVL_COLOR[1:0], level_q)};
        end else begin
            rgb_d = bg_rgb;
        end
    end

    // Output decode: registered values straight to the ports.
    always_comb begin
        phase = state_q;
        level = level_q;
        hsync = hsync_q;
        vsync = vsync_q;
        rgb   = rgb_q;
    end

endmodule

// File: tb/tb_overlay_fade_mixer.sv
// tb/tb_overlay_fade_mixer.sv - directed scoreboard bench for overlay_fade_mixer
module tb_overlay_fade_mixer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       hsync_in;
    logic       vsync_in;
    logic       display_on;
    logic       overlay_active;
    logic [5:0] bg_rgb;
    logic       hsync;
    logic       vsync;
    logic [5:0] rgb;
    logic [1:0] level;
    logic [2:0] phase;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];

    localparam logic [5:0] BG = 6'b000011;
    localparam logic [5:0] P1 = 6'b010100;
    localparam logic [5:0] P2 = 6'b100100;
    localparam logic [5:0] P3 = 6'b110100;

    overlay_fade_mixer #(
        .OVL_COLOR   (6'b110100),
        .HIDE_FRAMES (2),
        .FADE_FRAMES (1),
        .HOLD_FRAMES (2),
        .BLINK_FRAMES(1),
        .BLINK_COUNT (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .display_on    (display_on),
        .overlay_active(overlay_active),
        .bg_rgb        (bg_rgb),
        .hsync         (hsync),
        .vsync         (vsync),
        .rgb           (rgb),
        .level         (level),
        .phase         (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] p, input logic [1:0] l);
        chk(tag, {3'b000, phase, level}, {3'b000, p, l});
    endtask

    // One clock: drive inputs, queue the expected {hsync,vsync,rgb}, pop after the edge.
    task automatic cyc(input logic hs, input logic vs, input logic de, input logic ov,
                       input logic [5:0] bg, input logic [5:0] exp_rgb, input string tag);
        logic [7:0] want;
        @(negedge clk);
        hsync_in       = hs;
        vsync_in       = vs;
        display_on     = de;
        overlay_active = ov;
        bg_rgb         = bg;
        sb_q.push_back({hs, vs, exp_rgb});
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        chk(tag, {hsync, vsync, rgb}, want);
    endtask

    // One short frame; the tick lands on a visible pixel, which must still use the old level.
    task automatic frame(input logic en, input logic ov, input logic [5:0] bg,
                         input logic [5:0] exp_vis, input string tag);
        enable = en;
        cyc(1'b1, 1'b1, 1'b1, ov, bg, exp_vis, tag);
        cyc(1'b0, 1'b1, 1'b1, ov, bg, exp_vis, tag);
        cyc(1'b1, 1'b0, 1'b1, ov, bg, exp_vis, tag);
        cyc(1'b1, 1'b0, 1'b0, ov, bg, 6'd0, tag);
        cyc(1'b1, 1'b1, 1'b0, ov, bg, 6'd0, tag);
    endtask

    initial begin
        logic hs_r, vs_r, de_r;
        logic [5:0] bg_r;

        rst = 1'b1; enable = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        display_on = 1'b0; overlay_active = 1'b0; bg_rgb = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {hsync, vsync, rgb}, 8'b1100_0000);
        chk_st("rst_state", 3'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // No vsync edges: nothing moves.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, BG, 6'd0, "idle");
        chk_st("idle_state", 3'd0, 2'd0);

        // Hide, fade in.
        frame(1'b1, 1'b1, BG, BG, "hide0"); chk_st("hide0_st", 3'd0, 2'd0);
        frame(1'b1, 1'b1, BG, BG, "hide1"); chk_st("hide1_st", 3'd1, 2'd0);
        frame(1'b1, 1'b1, BG, BG, "fin0");  chk_st("fin0_st", 3'd1, 2'd1);
        frame(1'b1, 1'b1, BG, P1, "fin1");  chk_st("fin1_st", 3'd1, 2'd2);

        // Pixel rule at level 2.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, BG, P2, "lvl2_ov");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, BG, BG, "lvl2_bg");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, BG, 6'd0, "lvl2_blank");

        frame(1'b1, 1'b1, BG, P2, "fin2");  chk_st("fin2_st", 3'd2, 2'd3);
        frame(1'b1, 1'b1, BG, P3, "show0"); chk_st("show0_st", 3'd2, 2'd3);
        frame(1'b1, 1'b1, BG, P3, "show1"); chk_st("show1_st", 3'd3, 2'd3);

        // Blink: on, off, on, off, on (last one already fading out).
        frame(1'b1, 1'b1, BG, P3, "blk_on0");  chk_st("blk_on0_st", 3'd3, 2'd3);
        frame(1'b1, 1'b1, BG, BG, "blk_off0"); chk_st("blk_off0_st", 3'd3, 2'd3);
        frame(1'b1, 1'b1, BG, P3, "blk_on1");  chk_st("blk_on1_st", 3'd3, 2'd3);
        frame(1'b1, 1'b1, BG, BG, "blk_off1"); chk_st("blk_off1_st", 3'd4, 2'd3);

        // Fade out.
        frame(1'b1, 1'b1, BG, P3, "fout3"); chk_st("fout3_st", 3'd4, 2'd2);
        frame(1'b1, 1'b1, BG, P2, "fout2"); chk_st("fout2_st", 3'd4, 2'd1);
        frame(1'b1, 1'b1, BG, P1, "fout1"); chk_st("fout1_st", 3'd0, 2'd0);

        // Second cycle up to SHOW.
        frame(1'b1, 1'b1, BG, BG, "rehide0"); chk_st("rehide0_st", 3'd0, 2'd0);
        frame(1'b1, 1'b1, BG, BG, "rehide1"); chk_st("rehide1_st", 3'd1, 2'd0);
        frame(1'b1, 1'b1, BG, BG, "refin0");  chk_st("refin0_st", 3'd1, 2'd1);
        frame(1'b1, 1'b1, BG, P1, "refin1");  chk_st("refin1_st", 3'd1, 2'd2);
        frame(1'b1, 1'b1, BG, P2, "refin2");  chk_st("refin2_st", 3'd2, 2'd3);

        // Enable glitch between ticks is ignored.
        enable = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, BG, P3, "en_glitch");
        frame(1'b1, 1'b1, BG, P3, "en_glitch_f"); chk_st("en_glitch_st", 3'd2, 2'd3);

        // Enable low at a tick drops to HIDDEN.
        enable = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, BG, P3, "en_low_vis");
        chk_st("en_low_pre", 3'd2, 2'd3);
        frame(1'b0, 1'b1, BG, P3, "en_low_tick"); chk_st("en_low_st", 3'd0, 2'd0);
        frame(1'b0, 1'b1, BG, BG, "en_held");     chk_st("en_held_st", 3'd0, 2'd0);
        frame(1'b1, 1'b1, BG, BG, "en_up0");      chk_st("en_up0_st", 3'd0, 2'd0);
        frame(1'b1, 1'b1, BG, BG, "en_up1");      chk_st("en_up1_st", 3'd1, 2'd0);

        // Asynchronous reset mid-frame.
        @(negedge clk);
        hsync_in = 1'b0; vsync_in = 1'b1; display_on = 1'b1;
        overlay_active = 1'b1; bg_rgb = 6'b101010;
        @(posedge clk);
        #1;
        chk("pre_rst", {hsync, vsync, rgb}, 8'b0110_1010);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {hsync, vsync, rgb}, 8'b1100_0000);
        chk_st("mid_rst_st", 3'd0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        frame(1'b1, 1'b1, BG, BG, "post_rst0"); chk_st("post_rst0_st", 3'd0, 2'd0);
        frame(1'b1, 1'b1, BG, BG, "post_rst1"); chk_st("post_rst1_st", 3'd1, 2'd0);

        // Random sync/pixel traffic with the overlay masked off.
        for (int i = 0; i < 60; i++) begin
            hs_r = 1'($urandom_range(0, 1));
            vs_r = 1'($urandom_range(0, 1));
            de_r = 1'($urandom_range(0, 1));
            bg_r = 6'($urandom_range(0, 63));
            cyc(hs_r, vs_r, de_r, 1'b0, bg_r, de_r ? bg_r : 6'd0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
